// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side handshake and FIFO write-port bundle for fifo_wr_arbiter.
// slave  = arbiter view, master = producers plus FIFO (or a testbench).
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 8
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*DW-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  fifo_wr;
    logic [DW-1:0]         fifo_din;
    logic                  fifo_full;
    logic [GW-1:0]         grant_id;
    logic                  busy;

    modport slave (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_wr, fifo_din, grant_id, busy
    );

    modport master (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_wr, fifo_din, grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: NUM_REQ valid/ready producers share one FIFO
// write port. A winner keeps the port for up to BURST_LEN beats; each new
// grant costs one IDLE arbitration cycle. Backpressure comes only from
// fifo_full, there is no local occupancy tracking and no data buffering.
//
// state | meaning
// IDLE  | no beats; pick next valid producer after last_owner
// BURST | owner's beats pass straight through to the FIFO
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DW        = 8,
    parameter int BURST_LEN = 4
) (
    input logic               clk,
    input logic               rst,
    fifo_wr_arbiter_if.slave  bus
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(BURST_LEN) + 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   owner_q, owner_d;
    logic [GW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [GW-1:0]      pick;
    logic               pick_vld;
    logic [GW-1:0]      cand;
    logic               own_valid;
    logic [DW-1:0]      own_data;
    logic [NUM_REQ-1:0] ready_c;
    logic               wr_c;
    logic [DW-1:0]      din_c;

    // Round-robin search starting one past the last owner, wrapping to 0.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GW'((int'(last_q) + k) % NUM_REQ);
            if (!pick_vld && bus.req_valid[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    // Select the current owner's valid and data with constant indices.
    always_comb begin
        own_valid = 1'b0;
        own_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == GW'(i)) begin
                own_valid = bus.req_valid[i];
                own_data  = bus.req_data[i*DW +: DW];
            end
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        ready_c = '0;
        wr_c    = 1'b0;
        din_c   = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    owner_d = pick;
                    last_d  = pick;
                    cnt_d   = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                ready_c[owner_q] = !bus.fifo_full;
                din_c            = own_data;
                if (!own_valid) begin
                    // Owner went quiet: give the port up without a beat.
                    state_d = IDLE;
                end else if (!bus.fifo_full) begin
                    wr_c  = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(BURST_LEN - 1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and ownership registers; reset restarts priority at index 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= GW'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset must suppress strobes even in the cycle the state is still BURST.
    assign bus.req_ready = rst ? '0 : ready_c;
    assign bus.fifo_wr   = wr_c & ~rst;
    assign bus.fifo_din  = din_c;
    assign bus.grant_id  = owner_q;
    assign bus.busy      = (state_q == BURST);
endmodule
